rr_packet_arbiter: RTL and testbench

- Parametrised round-robin arbiter with a registered grant. It succeeds the standalone arbitration pointer block by absorbing the pointer and adding request selection, grant generation and optional packet locking.
- Sits in front of a shared output or resource. It arbitrates N input ports and holds the grant for a whole packet or a single transfer.
- Pointer fairness: after a release, the port just served gets lowest priority.

---
 rtl/rr_packet_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_packet_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter with a registered one-hot grant.
// The grant is held for a whole packet (lock_enable=1) or a single transfer
// (lock_enable=0). The port just released drops to lowest priority, and
// re-arbitration happens on the release edge so back-to-back grants have no
// idle bubble.
module rr_packet_arbiter #(
  parameter int number_ports = 4,
  parameter int lock_enable  = 1,
  localparam int IW  = (number_ports > 1) ? $clog2(number_ports) : 1,
  localparam int IW1 = IW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [number_ports-1:0] req,
  input  logic [number_ports-1:0] last,
  input  logic                    ready,
  output logic [number_ports-1:0] grant,
  output logic                    grant_valid,
  output logic [IW-1:0]           grant_index,
  output logic [IW-1:0]           pointer
);

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t                  r_state, w_state_next;
  logic [number_ports-1:0] r_grant, w_grant_next;
  logic [IW-1:0]           r_grant_index, w_grant_index_next;
  logic [IW-1:0]           r_pointer, w_pointer_next;

  logic                    w_req_g;
  logic                    w_last_g;
  logic                    w_release;
  logic [IW-1:0]           w_pointer_inc;
  logic [IW-1:0]           w_search_base;
  logic [IW1-1:0]          w_cand;
  logic [IW-1:0]           w_pick_index;
  logic                    w_pick_found;
  logic [number_ports-1:0] w_pick_onehot;

  // Request/last of the currently granted port, taken through the one-hot
  // grant so no index can ever fall outside the port range.
  assign w_req_g  = |(req & r_grant);
  assign w_last_g = |(last & r_grant);

  // Release on abandon, or on a transfer that ends the packet (or any
  // transfer when packets are not locked).
  assign w_release = (r_state == S_GRANTED) &&
                     (!w_req_g || (ready && ((lock_enable == 0) || w_last_g)));

  // Port after the one being released, with an explicit wrap so that
  // non-power-of-two port counts stay inside 0..number_ports-1.
  assign w_pointer_inc = (r_grant_index == IW'(number_ports - 1)) ? '0
                                                                  : r_grant_index + IW'(1);

  // A release re-arbitrates with the pointer it is about to write.
  assign w_search_base = w_release ? w_pointer_inc : r_pointer;

  // Circular first-set search starting at w_search_base; walking the offsets
  // from farthest to nearest lets the nearest requester overwrite the rest.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_index = '0;
    w_cand       = '0;
    for (int k = number_ports - 1; k >= 0; k--) begin
      w_cand = {1'b0, w_search_base} + IW1'(k);
      if (w_cand >= IW1'(number_ports)) begin
        w_cand = w_cand - IW1'(number_ports);
      end
      if (req[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_index = w_cand[IW-1:0];
      end
    end
  end

  // One-hot decode of the search result (all-zero when nothing requests).
  for (genvar gi = 0; gi < number_ports; gi++) begin : g_onehot
    assign w_pick_onehot[gi] = w_pick_found && (w_pick_index == IW'(gi));
  end

  // Next-state and next-grant selection.
  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_grant_index_next = r_grant_index;
    w_pointer_next     = r_pointer;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_state_next       = S_GRANTED;
          w_grant_next       = w_pick_onehot;
          w_grant_index_next = w_pick_index;
        end
      end
      S_GRANTED: begin
        if (w_release) begin
          w_pointer_next     = w_pointer_inc;
          w_grant_next       = w_pick_onehot;
          w_grant_index_next = w_pick_index;
          w_state_next       = w_pick_found ? S_GRANTED : S_IDLE;
        end
      end
      default: begin
        w_state_next       = S_IDLE;
        w_grant_next       = '0;
        w_grant_index_next = '0;
      end
    endcase
  end

  // State, grant and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_index <= '0;
      r_pointer     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_grant_index <= w_grant_index_next;
      r_pointer     <= w_pointer_next;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign grant_index = r_grant_index;
  assign pointer     = r_pointer;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Testbench for rr_packet_arbiter: three instances (4 ports locked, 3 ports
// locked, 4 ports unlocked) checked every cycle against a behavioural model,
// plus directed sequences with hand-computed expectations.
module tb_rr_packet_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: number_ports=4, lock_enable=1
  logic       rst_a, rdy_a;
  logic [3:0] req_a, last_a, gnt_a;
  logic       vld_a;
  logic [1:0] idx_a, ptr_a;
  // Instance B: number_ports=3, lock_enable=1
  logic       rst_b, rdy_b;
  logic [2:0] req_b, last_b, gnt_b;
  logic       vld_b;
  logic [1:0] idx_b, ptr_b;
  // Instance C: number_ports=4, lock_enable=0
  logic       rst_c, rdy_c;
  logic [3:0] req_c, last_c, gnt_c;
  logic       vld_c;
  logic [1:0] idx_c, ptr_c;

  rr_packet_arbiter #(.number_ports(4), .lock_enable(1)) dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .last(last_a), .ready(rdy_a),
    .grant(gnt_a), .grant_valid(vld_a), .grant_index(idx_a), .pointer(ptr_a));
  rr_packet_arbiter #(.number_ports(3), .lock_enable(1)) dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .last(last_b), .ready(rdy_b),
    .grant(gnt_b), .grant_valid(vld_b), .grant_index(idx_b), .pointer(ptr_b));
  rr_packet_arbiter #(.number_ports(4), .lock_enable(0)) dut_c (
    .clk(clk), .reset(rst_c), .req(req_c), .last(last_c), .ready(rdy_c),
    .grant(gnt_c), .grant_valid(vld_c), .grant_index(idx_c), .pointer(ptr_c));

  int checks = 0;
  int failures = 0;

  // Behavioural model: holder index (-1 = idle) and pointer per instance.
  int np[3] = '{4, 3, 4};
  int lk[3] = '{1, 1, 0};
  int mg[3];
  int mp[3];
  bit mvalid[3] = '{1'b0, 1'b0, 1'b0};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(int k, logic [3:0] rq);
    for (int o = 0; o < np[k]; o++) begin
      int i;
      i = (mp[k] + o) % np[k];
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_step(int k, logic rst, logic [3:0] rq, logic [3:0] ls, logic rd);
    int g;
    if (rst) begin
      mg[k] = -1;
      mp[k] = 0;
      mvalid[k] = 1'b1;
      return;
    end
    if (mg[k] < 0) begin
      mg[k] = pick(k, rq);
    end else begin
      g = mg[k];
      if (!rq[g] || (rd && (lk[k] == 0 || ls[g]))) begin
        mp[k] = (g + 1) % np[k];
        mg[k] = pick(k, rq);
      end
    end
  endfunction

  function automatic logic [3:0] model_grant(int k);
    return (mg[k] < 0) ? 4'b0000 : 4'(1 << mg[k]);
  endfunction

  always @(posedge clk) begin
    model_step(0, rst_a, req_a, last_a, rdy_a);
    model_step(1, rst_b, {1'b0, req_b}, {1'b0, last_b}, rdy_b);
    model_step(2, rst_c, req_c, last_c, rdy_c);
  end

  task automatic cmp(int k, string nm, logic [3:0] g, logic v, logic [1:0] i, logic [1:0] p);
    chk({nm, ".grant"}, 32'(g), 32'(model_grant(k)));
    chk({nm, ".valid"}, 32'(v), 32'(mg[k] >= 0));
    chk({nm, ".index"}, 32'(i), (mg[k] < 0) ? 32'd0 : 32'(mg[k]));
    chk({nm, ".pointer"}, 32'(p), 32'(mp[k]));
    chk({nm, ".ptr_range"}, 32'(int'(p) < np[k]), 32'd1);
  endtask

  // Per-cycle comparison on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (mvalid[0]) cmp(0, "A", gnt_a, vld_a, idx_a, ptr_a);
    if (mvalid[1]) cmp(1, "B", {1'b0, gnt_b}, vld_b, idx_b, ptr_b);
    if (mvalid[2]) cmp(2, "C", gnt_c, vld_c, idx_c, ptr_c);
  end

  function automatic logic [3:0] dut_grant(int k);
    case (k)
      0: return gnt_a;
      1: return {1'b0, gnt_b};
      default: return gnt_c;
    endcase
  endfunction
  function automatic logic [1:0] dut_idx(int k);
    case (k)
      0: return idx_a;
      1: return idx_b;
      default: return idx_c;
    endcase
  endfunction
  function automatic logic [1:0] dut_ptr(int k);
    case (k)
      0: return ptr_a;
      1: return ptr_b;
      default: return ptr_c;
    endcase
  endfunction
  function automatic logic dut_vld(int k);
    case (k)
      0: return vld_a;
      1: return vld_b;
      default: return vld_c;
    endcase
  endfunction

  // Hand-computed expectation checked against both the DUT and the model.
  task automatic lit(int k, string nm, logic [3:0] g, int idx, int p);
    chk({nm, ".grant"}, 32'(dut_grant(k)), 32'(g));
    chk({nm, ".valid"}, 32'(dut_vld(k)), 32'(g != 4'b0000));
    chk({nm, ".index"}, 32'(dut_idx(k)), 32'(idx));
    chk({nm, ".pointer"}, 32'(dut_ptr(k)), 32'(p));
    chk({nm, ".model_grant"}, 32'(model_grant(k)), 32'(g));
    chk({nm, ".model_pointer"}, 32'(mp[k]), 32'(p));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; req_a = 4'b1111; last_a = 4'b0000; rdy_a = 1'b0;
    rst_b = 1'b1; req_b = 3'b000;  last_b = 3'b000;  rdy_b = 1'b0;
    rst_c = 1'b1; req_c = 4'b0000; last_c = 4'b0000; rdy_c = 1'b0;

    // Reset held two cycles with all ports requesting.
    tick(); lit(0, "A.reset0", 4'b0000, 0, 0);
    tick(); lit(0, "A.reset1", 4'b0000, 0, 0);
    rst_a = 1'b0;
    tick(); lit(0, "A.first_grant", 4'b0001, 0, 0);

    // Fairness: single-transfer packets from every port.
    rdy_a = 1'b1; last_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      lit(0, $sformatf("A.fair%0d", i), 4'(1 << ((i + 1) % 4)), (i + 1) % 4, (i + 1) % 4);
    end

    // Packet lock on port 2.
    last_a = 4'b0010;
    tick(); lit(0, "A.lock_start", 4'b0100, 2, 2);
    last_a = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick(); lit(0, $sformatf("A.lock_hold%0d", i), 4'b0100, 2, 2);
    end
    last_a = 4'b0100;
    tick(); lit(0, "A.lock_next", 4'b1000, 3, 3);

    // Abandon and backpressure on port 1.
    req_a = 4'b0010; last_a = 4'b1000;
    tick(); lit(0, "A.grant1", 4'b0010, 1, 0);
    rdy_a = 1'b0; req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick(); lit(0, $sformatf("A.backpressure%0d", i), 4'b0010, 1, 0);
    end
    req_a = 4'b0001;
    tick(); lit(0, "A.abandon", 4'b0001, 0, 2);
    req_a = 4'b0000; rdy_a = 1'b1; last_a = 4'b0000;
    tick(); lit(0, "A.idle", 4'b0000, 0, 1);

    // Three ports: wrap from pointer 2 back to 0.
    rst_b = 1'b0; req_b = 3'b010; rdy_b = 1'b1; last_b = 3'b010;
    tick(); lit(1, "B.grant1", 4'b0010, 1, 0);
    req_b = 3'b101; last_b = 3'b000;
    tick(); lit(1, "B.grant2", 4'b0100, 2, 2);
    last_b = 3'b100;
    tick(); lit(1, "B.wrap", 4'b0001, 0, 0);
    last_b = 3'b001;
    tick(); lit(1, "B.after_wrap", 4'b0100, 2, 1);
    req_b = 3'b000;
    tick(); lit(1, "B.idle", 4'b0000, 0, 0);

    // Non-lock mode alternates per transfer, then reset mid-grant.
    rst_c = 1'b0; req_c = 4'b0011; last_c = 4'b0000; rdy_c = 1'b1;
    tick(); lit(2, "C.alt0", 4'b0001, 0, 0);
    tick(); lit(2, "C.alt1", 4'b0010, 1, 1);
    tick(); lit(2, "C.alt2", 4'b0001, 0, 2);
    tick(); lit(2, "C.alt3", 4'b0010, 1, 1);
    rst_c = 1'b1;
    tick(); lit(2, "C.mid_reset", 4'b0000, 0, 0);
    rst_c = 1'b0;

    // Randomized traffic on all three instances.
    for (int n = 0; n < 3000; n++) begin
      rst_a = ($urandom_range(0, 63) == 0);
      rst_b = ($urandom_range(0, 63) == 0);
      rst_c = ($urandom_range(0, 63) == 0);
      req_a = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
      req_b = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom);
      req_c = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
      last_a = 4'($urandom);
      last_b = 3'($urandom);
      last_c = 4'($urandom);
      rdy_a = ($urandom_range(0, 3) != 0);
      rdy_b = ($urandom_range(0, 3) != 0);
      rdy_c = ($urandom_range(0, 3) != 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
